// File: rtl/j1_irq_ctrl.sv
// j1_irq_ctrl: interrupt controller for the J1 core.
// Latches rising edges on irq_src into PEND. IO registers at BASE+0/2/4/6
// (PEND W1C, MASK, CTRL, VEC) are decoded on mem_addr[15:3].
// Drives a registered one-cycle `interrupt` that never fires in a cycle
// where code_addr[12] marks an upcoming fetch.
// Optional macro IRQ_SYNC_EN: adds a 2-flop synchronizer on every irq_src line.
//
// state | meaning
// IDLE  | waiting for GIE & pending&mask & no fetch hazard
// FIRE  | interrupt high for this one cycle; GIE already auto-cleared
module j1_irq_ctrl #(
    parameter int          NSRC = 8,
    parameter logic [15:0] BASE = 16'h4000
) (
    input  logic            clk,
    input  logic            resetq,
    input  logic [NSRC-1:0] irq_src,
    input  logic [12:0]     code_addr,
    input  logic [15:0]     mem_addr,
    input  logic            io_wr,
    input  logic            io_rd,
    input  logic [15:0]     dout,
    output logic [15:0]     io_rdata,
    output logic            io_rsel,
    output logic            interrupt
);
    typedef enum logic {IDLE = 1'b0, FIRE = 1'b1} state_t;

    localparam int          PADW    = 16 - NSRC;
    localparam logic [12:0] BASE_HI = BASE[15:3];

    state_t          state_q, state_d;
    logic [NSRC-1:0] src_s;
    logic [NSRC-1:0] cur_q, prev_q;
    logic [NSRC-1:0] pend_q, pend_d;
    logic [NSRC-1:0] mask_q, mask_d;
    logic            gie_q, gie_d;
    logic [15:0]     rdata_q, rdata_d;
    logic            rsel_q, rsel_d;
    logic [NSRC-1:0] rise, act;
    logic            any_act, fire_ok, fire;
    logic            hit, wr_pend, wr_mask, wr_ctrl;
    logic [1:0]      off;
    logic [15:0]     vec, rd_mux;
    logic            unused_ok;

    assign unused_ok = &{1'b0, mem_addr[0], code_addr[11:0], dout};

`ifdef IRQ_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous source pins.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq_src;
            sync2_q <= sync1_q;
        end
    end
    assign src_s = sync2_q;
`else
    assign src_s = irq_src;
`endif

    assign hit     = (mem_addr[15:3] == BASE_HI);
    assign off     = mem_addr[2:1];
    assign wr_pend = io_wr & hit & (off == 2'd0);
    assign wr_mask = io_wr & hit & (off == 2'd1);
    assign wr_ctrl = io_wr & hit & (off == 2'd2);

    assign rise    = cur_q & ~prev_q;
    assign act     = pend_q & mask_q;
    assign any_act = |act;

    // A CTRL write clearing GIE in the same cycle takes precedence over firing.
    assign fire_ok = gie_q & any_act & ~code_addr[12] & ~interrupt
                   & ~(wr_ctrl & ~dout[0]);

    // Lowest-numbered pending&enabled source, or all-ones when none.
    always_comb begin
        vec = 16'hFFFF;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (act[i]) vec = {12'd0, 4'(i)};
        end
    end

    // Register file next-state: new edges beat a simultaneous W1C.
    always_comb begin
        pend_d = (pend_q & ~(wr_pend ? dout[NSRC-1:0] : '0)) | rise;
        mask_d = wr_mask ? dout[NSRC-1:0] : mask_q;
        if (fire)         gie_d = 1'b0;
        else if (wr_ctrl) gie_d = dout[0];
        else              gie_d = gie_q;
    end

    // Fire FSM next-state.
    always_comb begin
        state_d = state_q;
        fire    = 1'b0;
        case (state_q)
            IDLE: begin
                if (fire_ok) begin
                    state_d = FIRE;
                    fire    = 1'b1;
                end
            end
            FIRE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Read mux and read-port next-state; misses keep the last data.
    always_comb begin
        case (off)
            2'd0:    rd_mux = {{PADW{1'b0}}, pend_q};
            2'd1:    rd_mux = {{PADW{1'b0}}, mask_q};
            2'd2:    rd_mux = {any_act, 14'd0, gie_q};
            default: rd_mux = vec;
        endcase
        rdata_d = rdata_q;
        rsel_d  = rsel_q;
        if (io_rd) begin
            rsel_d = hit;
            if (hit) rdata_d = rd_mux;
        end
    end

    // All controller state.
    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q <= IDLE;
            cur_q   <= '0;
            prev_q  <= '0;
            pend_q  <= '0;
            mask_q  <= '0;
            gie_q   <= 1'b0;
            rdata_q <= 16'd0;
            rsel_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= src_s;
            prev_q  <= cur_q;
            pend_q  <= pend_d;
            mask_q  <= mask_d;
            gie_q   <= gie_d;
            rdata_q <= rdata_d;
            rsel_q  <= rsel_d;
        end
    end

    assign interrupt = (state_q == FIRE);
    assign io_rdata  = rdata_q;
    assign io_rsel   = rsel_q;
endmodule
